// File: rtl/pe_arr.sv
// ============================================================================
// Module   : pe_arr
// Brief    : Output-stationary systolic MAC array; activations shift right,
//            weights shift down, each PE keeps a 32-bit running sum.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pe_arr_pe (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fire,
  input  logic [7:0]  a_in,
  input  logic [7:0]  w_in,
  output logic [7:0]  a_reg,
  output logic [7:0]  w_reg,
  output logic [31:0] acc
);

  logic [15:0] w_prod;

  assign w_prod = 16'(a_in) * 16'(w_in);

  // Reset input is active-high despite its name.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      a_reg <= 8'd0;
      w_reg <= 8'd0;
      acc   <= 32'd0;
    end else if (fire) begin
      a_reg <= a_in;
      w_reg <= w_in;
      acc   <= acc + {16'd0, w_prod};
    end
  end

endmodule

module pe_arr #(
  parameter int rows = 16,
  parameter int cols = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      fire,
  input  logic [0:8*cols-1]         in_w_port,
  input  logic [0:8*rows-1]         in_a_port,
  output logic [0:32*rows*cols-1]   outs_port
);

  logic [7:0]  a_q   [rows][cols];
  logic [7:0]  w_q   [rows][cols];
  logic [31:0] acc_q [rows][cols];

  for (genvar r = 0; r < rows; r++) begin : g_row
    for (genvar c = 0; c < cols; c++) begin : g_col
      logic [7:0] w_a_in;
      logic [7:0] w_w_in;

      if (c == 0) begin : g_a_edge
        assign w_a_in = in_a_port[8*r +: 8];
      end else begin : g_a_fwd
        assign w_a_in = a_q[r][c-1];
      end

      if (r == 0) begin : g_w_edge
        assign w_w_in = in_w_port[8*c +: 8];
      end else begin : g_w_fwd
        assign w_w_in = w_q[r-1][c];
      end

      pe_arr_pe u_pe (
        .clk   (clk),
        .rstn  (rstn),
        .fire  (fire),
        .a_in  (w_a_in),
        .w_in  (w_w_in),
        .a_reg (a_q[r][c]),
        .w_reg (w_q[r][c]),
        .acc   (acc_q[r][c])
      );

      // Row-major flattening: PE(r,c) lands at word r*cols+c.
      assign outs_port[32*(r*cols+c) +: 32] = acc_q[r][c];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pe_arr.sv
// ============================================================================
// Module   : tb_pe_arr
// Brief    : Directed self-checking bench for the pe_arr systolic MAC array.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pe_arr;

  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int NPE  = ROWS * COLS;

  logic                     clk;
  logic                     rstn;
  logic                     fire;
  logic [0:8*COLS-1]        in_w_port;
  logic [0:8*ROWS-1]        in_a_port;
  logic [0:32*NPE-1]        outs_port;
  logic [0:32*NPE-1]        snap;

  int tests_run = 0;
  int failed    = 0;

  pe_arr #(.rows(ROWS), .cols(COLS)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .fire      (fire),
    .in_w_port (in_w_port),
    .in_a_port (in_a_port),
    .outs_port (outs_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] outv(input int i);
    return outs_port[32*i +: 32];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Count of outputs that are non-zero, optionally skipping one index.
  function automatic int nonzero_count(input int skip);
    int n = 0;
    for (int i = 0; i < NPE; i++)
      if (i != skip && outv(i) != 32'd0) n++;
    return n;
  endfunction

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int r, input logic [7:0] v);
    in_a_port[8*r +: 8] = v;
  endtask

  task automatic set_w(input int c, input logic [7:0] v);
    in_w_port[8*c +: 8] = v;
  endtask

  task automatic do_reset;
    #2 rstn = 1'b1;
    #1 rstn = 1'b0;
  endtask

  initial begin
    int diffs;
    rstn      = 1'b1;
    fire      = 1'b0;
    in_w_port = '0;
    in_a_port = '0;

    // Reset held, then held with fire=1 and busy ports.
    edges(2);
    check("reset_zero", 32'(nonzero_count(-1)), 32'd0);
    fire = 1'b1;
    for (int i = 0; i < ROWS; i++) set_a(i, 8'd7);
    for (int i = 0; i < COLS; i++) set_w(i, 8'd9);
    edges(3);
    check("reset_fire_zero", 32'(nonzero_count(-1)), 32'd0);
    fire      = 1'b0;
    in_w_port = '0;
    in_a_port = '0;
    rstn      = 1'b0;
    edges(1);

    // Single product.
    set_a(0, 8'd3);
    set_w(0, 8'd5);
    fire = 1'b1;
    edges(1);
    fire = 1'b0;
    check("single_out0", outv(0), 32'd15);
    check("single_others", 32'(nonzero_count(0)), 32'd0);

    // Run some more, then an asynchronous reset between edges.
    fire = 1'b1;
    edges(3);
    fire = 1'b0;
    check("pre_async_nonzero", outv(0), 32'd60);
    do_reset();
    check("async_reset_zero", 32'(nonzero_count(-1)), 32'd0);
    in_a_port = '0;
    in_w_port = '0;
    edges(1);

    // Horizontal propagation: one pulse of a=2 on row 0, all w=1.
    for (int i = 0; i < COLS; i++) set_w(i, 8'd1);
    set_a(0, 8'd2);
    fire = 1'b1;
    edges(1);
    set_a(0, 8'd0);
    check("horiz_e1_c0", outv(0), 32'd2);
    check("horiz_e1_c1", outv(1), 32'd0);
    edges(4);
    check("horiz_e5_c4", outv(4), 32'd2);
    check("horiz_e5_c5", outv(5), 32'd0);
    edges(11);
    diffs = 0;
    for (int c = 0; c < COLS; c++) if (outv(c) != 32'd2) diffs++;
    check("horiz_row0_all2", 32'(diffs), 32'd0);
    diffs = 0;
    for (int i = COLS; i < NPE; i++) if (outv(i) != 32'd0) diffs++;
    check("horiz_rows_zero", 32'(diffs), 32'd0);
    fire = 1'b0;

    // Full-array fill: a=1 everywhere, w[c]=c, 20 enabled edges.
    do_reset();
    for (int i = 0; i < ROWS; i++) set_a(i, 8'd1);
    for (int i = 0; i < COLS; i++) set_w(i, 8'(i));
    fire = 1'b1;
    edges(20);
    fire = 1'b0;
    check("fill_pe_3_5", outv(53), 32'd75);
    check("fill_pe_0_0", outv(0), 32'd0);
    check("fill_pe_15_15", outv(255), 32'd75);
    check("fill_pe_1_1", outv(17), 32'd19);

    // Fire hold with random port data.
    snap = outs_port;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < ROWS; i++) set_a(i, 8'($urandom_range(255)));
      for (int i = 0; i < COLS; i++) set_w(i, 8'($urandom_range(255)));
      edges(1);
    end
    diffs = 0;
    for (int i = 0; i < NPE; i++) if (outv(i) != snap[32*i +: 32]) diffs++;
    check("hold_unchanged", 32'(diffs), 32'd0);
    for (int i = 0; i < ROWS; i++) set_a(i, 8'd1);
    for (int i = 0; i < COLS; i++) set_w(i, 8'(i));
    fire = 1'b1;
    edges(1);
    fire = 1'b0;
    check("resume_pe_3_5", outv(53), 32'd80);
    check("resume_pe_15_15", outv(255), 32'd90);
    check("resume_pe_1_1", outv(17), 32'd20);

    // Wrap-around: 255*255 accumulated 66052 times.
    do_reset();
    in_a_port = '0;
    in_w_port = '0;
    set_a(0, 8'd255);
    set_w(0, 8'd255);
    fire = 1'b1;
    edges(66052);
    fire = 1'b0;
    check("wrap_out0", outv(0), 32'd64004);
    check("wrap_out1", outv(1), 32'd0);
    check("wrap_out16", outv(16), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pe_arr.md
# pe_arr

Output-stationary systolic multiply-accumulate array of `rows` × `cols` processing elements (PEs), used as the matrix-multiply core.
- Activations enter at the left edge, one byte per row, and shift rightward.
- Weights enter at the top edge, one byte per column, and shift downward.
- Every PE accumulates the products of the operand pairs passing through it into a 32-bit result that is exposed in parallel on a flat output bus.

## Interface
- `rows`, 16, number of PE rows; one activation lane per row.
- `cols`, 16, number of PE columns; one weight lane per column.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rstn`  input  1  asynchronous, active-high reset. Despite the name, `rstn`=1 clears all state immediately, independent of `clk`.
- `fire`  input  1  global advance enable; all PEs shift and accumulate only when `fire`=1.
- `in_w_port`  input  8*cols  weight bus declared `[0:8*cols-1]`. Column c's byte is bits `[8*c : 8*c+7]`, so c=0 is the most-significant byte.
- `in_a_port`  input  8*rows  activation bus, `[0:8*rows-1]`. Row r's byte is bits `[8*r : 8*r+7]`.
- `outs_port`  output  32*rows*cols  accumulator bus, `[0:32*rows*cols-1]`. PE(r,c) is at index i = r*cols + c, bits `[32*i : 32*i+31]`; row-major.

## Operation
- Each PE(r,c) holds three registers:
  - `a_reg` (8 b)
  - `w_reg` (8 b)
  - `acc` (32 b)
- Operand sources for PE(r,c):
  - `a_in`: `in_a_port` row r when c=0, else `a_reg` of PE(r,c-1).
  - `w_in`: `in_w_port` column c when r=0, else `w_reg` of PE(r-1,c).
- Rising edge with `fire`=1 and reset deasserted:
  - `a_reg` ← `a_in`; `w_reg` ← `w_in`.
  - `acc` ← `acc` + `a_in`*`w_in`.
- Arithmetic rules:
  - Operands are unsigned 8-bit; the product is an unsigned 16-bit value, zero-extended to 32 bits.
  - Accumulation is modulo 2^32: wraps silently, with no saturation and no overflow flag.
- Rising edge with `fire`=0: all registers hold. Port values are ignored.
- The block applies no input skew. The caller staggers row and column data if true matrix alignment is wanted.
- There is no clear-accumulator input; only reset zeroes `acc`.
- `outs_port` is driven directly from the `acc` registers, with no output logic beyond wiring.
- The array is built as a generate grid of identical PE instances. No PE-to-PE combinational path exists other than the registered `a`/`w` forwarding.

## Timing
- Reset:
  - Assertion asynchronously clears every `a_reg`, `w_reg` and `acc` to 0, so `outs_port` = all zeros.
  - Reset mid-run discards all in-flight operands and partial sums.
  - The first accumulation happens on the first rising edge with reset low and `fire`=1.
- Port inputs are sampled on the rising edge. A port byte affects `outs_port` for PE(r,0) or PE(0,c) one edge later.
- Operand propagation:
  - An activation presented on row r at edge k reaches PE(r,c)'s multiplier at edge k+c.
  - A weight presented on column c at edge k is used by PE(r,c) at edge k+r.
  - These counts are in fire-enabled edges only; `fire`=0 edges do not advance the pipeline.
- With constant port values held from the first enabled edge, PE(r,c) first adds a non-zero product on enabled edge max(r,c)+1. Before that, its upstream registers still hold reset zeros.
- After T enabled edges with constant a=A and w[c]=W_c: `acc`(r,c) = A*W_c*max(0, T-max(r,c)) mod 2^32.
- Outputs change only on enabled rising edges or on reset. They are stable throughout `fire`=0 intervals.

## Test plan
- Reset:
  - Run any stimulus, then assert `rstn`=1 between clock edges → all 256 outputs read 0 before the next edge.
  - Hold reset with `fire`=1 → outputs remain 0.
- Single product:
  - After reset, set `in_a` row0=3 and `in_w` col0=5 with all other lanes 0, then give 1 enabled edge → outs[0]=15.
  - All other outputs read 0.
- Horizontal propagation:
  - Row0 a=2 for one enabled edge then 0; all w=1 held; `fire`=1.
  - → outs[c] becomes 2 at edge c+1 and stays 2.
  - All rows r≥1 remain 0.
- Full-array fill:
  - Default 16×16, all a=1, w[c]=c held, `fire`=1 for 20 edges.
  - → outs[53] (PE(3,5)) = 75, outs[0] = 0, outs[255] (PE(15,15)) = 75, outs[17] (PE(1,1)) = 19.
- Fire hold: set `fire`=0 for 5 cycles with random port data → every output unchanged; the next enabled edge resumes exactly as if no pause occurred.
- Wrap-around: a row0=255 and w col0=255 held for 66052 enabled edges → outs[0] = 64004, i.e. (66052*65025) mod 2^32.
